// File: rtl/iter_multiplier_if.sv
// Handshake bundle for iter_multiplier: operand/mode request, abort, and product response.
interface iter_multiplier_if #(
  parameter int unsigned WIDTH = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   m_signed;
  logic [WIDTH-1:0]       src_a;
  logic [WIDTH-1:0]       src_b;
  logic                   abort;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     product;
  logic                   busy;

  modport master (
    output in_valid, m_signed, src_a, src_b, abort, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, m_signed, src_a, src_b, abort, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/iter_multiplier.sv
// Iterative shift-and-add multiplier on operand magnitudes, with sign fix-up in a final cycle.
module iter_multiplier #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned EARLY_EXIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  iter_multiplier_if.slave  bus
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e                 state_q, state_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [2*WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   sign_q, sign_d;
  logic [2*WIDTH-1:0]     product_q, product_d;

  logic [WIDTH-1:0]       mag_a, mag_b;

  // Magnitude of the most negative value still fits as an unsigned WIDTH-bit number.
  assign mag_a = (bus.m_signed && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
  assign mag_b = (bus.m_signed && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    product_d = product_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          sign_d   = bus.m_signed & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
          acc_d    = '0;
          if (mag_a == '0 || mag_b == '0) begin
            product_d = '0;
            state_d   = StDone;
          end else begin
            cnt_d   = CntW'(WIDTH);
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_d == '0 || (EARLY_EXIT != 0 && mplier_d == '0)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        product_d = sign_q ? -acc_q : acc_q;
        state_d   = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over accept and handshake; a result being fixed up is dropped.
    if (bus.abort) begin
      state_d   = StIdle;
      product_d = product_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      product_q <= product_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q == StRun) || (state_q == StFix);
  assign bus.product   = product_q;

endmodule

// File: tb/tb_iter_multiplier.sv
// Randomized and directed bench for iter_multiplier (WIDTH=8), with and without early exit.
module tb_iter_multiplier;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         m_signed = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         abort = 1'b0;
  logic         out_ready = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  iter_multiplier_if #(.WIDTH(W)) ifc0 ();
  iter_multiplier_if #(.WIDTH(W)) ifc1 ();

  assign ifc0.in_valid  = in_valid;
  assign ifc0.m_signed  = m_signed;
  assign ifc0.src_a     = src_a;
  assign ifc0.src_b     = src_b;
  assign ifc0.abort     = abort;
  assign ifc0.out_ready = out_ready;
  assign ifc1.in_valid  = in_valid;
  assign ifc1.m_signed  = m_signed;
  assign ifc1.src_a     = src_a;
  assign ifc1.src_b     = src_b;
  assign ifc1.abort     = abort;
  assign ifc1.out_ready = out_ready;

  iter_multiplier #(.WIDTH(W), .EARLY_EXIT(0)) dut0 (.clk(clk), .reset(reset), .bus(ifc0));
  iter_multiplier #(.WIDTH(W), .EARLY_EXIT(1)) dut1 (.clk(clk), .reset(reset), .bus(ifc1));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input bit s, input logic [7:0] a, input logic [7:0] b);
    int ia, ib;
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    return 16'(ia * ib);
  endfunction

  // Number of significant bits in |b|.
  function automatic int ref_bits(input bit s, input logic [7:0] b);
    int mag, k;
    mag = s ? int'($signed(b)) : int'(b);
    if (mag < 0) mag = -mag;
    k = 0;
    while (mag > 0) begin
      k++;
      mag = mag / 2;
    end
    return k;
  endfunction

  // Presents one operation; returns #1 after the accepting edge with operands scrambled.
  task automatic start_op(input bit s, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    m_signed = s;
    src_a    = a;
    src_b    = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    src_a    = W'($urandom);
    src_b    = W'($urandom);
    m_signed = 1'($urandom);
  endtask

  task automatic run_op(input bit s, input logic [7:0] a, input logic [7:0] b);
    int lat0, lat1, busy0, busy1, k;
    logic [15:0] p0, p1, exp;
    bit zero;
    lat0 = 0; lat1 = 0; busy0 = 0; busy1 = 0; p0 = 'x; p1 = 'x;
    exp  = ref_mul(s, a, b);
    zero = (a == 0) || (b == 0);
    k    = ref_bits(s, b);
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("in_ready0", ifc0.in_ready, 1'b1);
    start_op(s, a, b);
    for (int e = 1; e <= 40; e++) begin
      if (e > 1) begin
        @(posedge clk);
        #1;
      end
      if (lat0 == 0) begin
        if (ifc0.busy) busy0++;
        if (ifc0.out_valid) begin
          lat0 = e;
          p0   = ifc0.product;
        end
      end
      if (lat1 == 0) begin
        if (ifc1.busy) busy1++;
        if (ifc1.out_valid) begin
          lat1 = e;
          p1   = ifc1.product;
        end
      end
      if (lat0 != 0 && lat1 != 0) break;
    end
    check_eq("product0", p0, exp);
    check_eq("product1", p1, exp);
    check_eq("latency0", lat0, zero ? 1 : W + 2);
    check_eq("latency1", lat1, zero ? 1 : k + 2);
    check_eq("busy0", busy0, zero ? 0 : W + 1);
    check_eq("busy1", busy1, zero ? 0 : k + 1);
    @(posedge clk);
    #1;
    check_eq("idle_hold", {ifc0.in_ready, ifc0.out_valid, ifc0.product}, {2'b10, exp});
  endtask

  initial begin
    int w, nv;
    #1;
    check_eq("rst_state0", {ifc0.in_ready, ifc0.out_valid, ifc0.busy, ifc0.product},
             {3'b100, 16'h0});
    check_eq("rst_state1", {ifc1.in_ready, ifc1.out_valid, ifc1.busy, ifc1.product},
             {3'b100, 16'h0});
    repeat (3) @(negedge clk);
    reset = 1'b0;

    run_op(1'b0, 8'hFF, 8'hFF);
    run_op(1'b1, 8'hFD, 8'h05);
    run_op(1'b1, 8'h80, 8'h80);
    run_op(1'b0, 8'h00, 8'h5A);
    run_op(1'b0, 8'h07, 8'h01);
    run_op(1'b0, 8'h07, 8'h80);
    run_op(1'b1, 8'h7F, 8'h80);

    // Backpressure: result must be held and new requests ignored.
    out_ready = 1'b0;
    start_op(1'b0, 8'h03, 8'h07);
    w = 0;
    while (!ifc0.out_valid && w < 30) begin
      @(posedge clk);
      #1;
      w++;
    end
    check_eq("bp_done", ifc0.out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      src_a = W'($urandom);
      src_b = W'($urandom);
      @(posedge clk);
      #1;
      check_eq("bp_hold", {ifc0.out_valid, ifc0.in_ready, ifc0.product}, {2'b10, 16'h0015});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp_release0", {ifc0.in_ready, ifc0.out_valid}, 2'b10);
    check_eq("bp_release1", {ifc1.in_ready, ifc1.out_valid}, 2'b10);

    // Abort during the 4th RUN cycle.
    start_op(1'b0, 8'h55, 8'h33);
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort_busy", ifc0.busy, 1'b1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check_eq("abort_idle", {ifc0.in_ready, ifc0.out_valid, ifc0.busy}, 3'b100);
    nv = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      nv += int'(ifc0.out_valid) + int'(ifc1.out_valid);
    end
    check_eq("abort_no_valid", nv, 0);
    run_op(1'b0, 8'h03, 8'h07);

    // Reset while in FIX.
    start_op(1'b0, 8'hFF, 8'hFF);
    repeat (8) @(posedge clk);
    #1;
    check_eq("fix_busy", ifc0.busy, 1'b1);
    reset = 1'b1;
    #1;
    check_eq("rst_mid0", {ifc0.in_ready, ifc0.out_valid, ifc0.busy, ifc0.product},
             {3'b100, 16'h0});
    check_eq("rst_mid1", {ifc1.in_ready, ifc1.out_valid, ifc1.busy, ifc1.product},
             {3'b100, 16'h0});
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nv = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      nv += int'(ifc0.out_valid) + int'(ifc1.out_valid);
    end
    check_eq("rst_no_valid", nv, 0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] a, b;
      a = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_op(1'($urandom), a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
